sigdelay_ctrl: RTL
==================

SIGDELAY_CTRL -- requirements
Module: sigdelay_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 9, the RAM address width; buffer depth is 2**ADDRESS_WIDTH.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have en  input  1  block enable.
REQ-005 SHALL have sample_valid  input  1  one new input sample present this cycle.
REQ-006 SHALL have offset  input  ADDRESS_WIDTH  delay in samples between write and read pointers.
REQ-007 SHALL have wr  output  1  RAM write strobe.
REQ-008 SHALL have wr_addr  output  ADDRESS_WIDTH  RAM write address.
REQ-009 SHALL have rd  output  1  RAM read strobe.
REQ-010 SHALL have rd_addr  output  ADDRESS_WIDTH  RAM read address.
REQ-011 SHALL have out_valid  output  1  RAM dout holds a valid delayed sample this cycle.
REQ-012 SHALL have filling  output  1  high while the delay line is priming.

Function
REQ-013 SHALL implement states IDLE, FILL, RUN; all outputs registered.
REQ-014 SHALL compute effective offset eoff = (offset==0) ? 1 : offset.
REQ-015 IDLE: wr=rd=0; on en=1 go to FILL, clear fill counter, latch eoff.
REQ-016 Per accepted sample (en=1 and sample_valid=1), next cycle: wr=1, wr_addr=current write pointer; then pointer increments modulo 2**ADDRESS_WIDTH (wraps max->0).
REQ-017 FILL: each accepted sample increments fill counter; when fill counter reaches latched eoff, the same edge moves to RUN; rd stays 0 throughout FILL.
REQ-018 RUN: each accepted sample produces, next cycle, wr=1 and rd=1 together, rd_addr = (write pointer - latched eoff) mod 2**ADDRESS_WIDTH, computed on the pre-increment pointer.
REQ-019 wr and rd SHALL be single-cycle pulses; 0 in cycles with no accepted sample.
REQ-020 out_valid SHALL equal rd delayed by exactly one clock (RAM read latency 1).
REQ-021 filling SHALL be 1 exactly when state is FILL.
REQ-022 offset differing from latched eoff while in RUN or FILL SHALL return to FILL, relatch, clear fill counter; write pointer not reset; rd=0 from the following cycle.
REQ-023 en=0 in any state SHALL go to IDLE next edge, suppress wr/rd, retain write pointer; out_valid still follows a pending rd one cycle later.
REQ-024 sample_valid while en=0 SHALL be ignored.
REQ-025 Back-to-back sample_valid every cycle SHALL be sustained with no dropped writes.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, write pointer 0, fill counter 0, latched eoff 1, wr=0, rd=0, wr_addr=0, rd_addr=0, out_valid=0, filling=0.
REQ-027 Reset asserted mid-FILL or mid-RUN SHALL discard all progress; first accepted sample after release writes address 0.
REQ-028 Release SHALL take effect on the first rising clk after rst_n rises; no outputs change before it.

Verification
REQ-029 Reset, en=1, offset=4, sample_valid continuous -> wr_addr 0,1,2,3 with filling=1, rd=0; 5th sample wr_addr=4, rd=1, rd_addr=0; out_valid next cycle.
REQ-030 offset=4, run 520 samples -> wr_addr wraps 511->0; at wr_addr=2 rd_addr=510.
REQ-031 offset=0 -> behaves as offset=1: second sample wr_addr=1, rd_addr=0.
REQ-032 In RUN change offset 4->8 -> filling=1, rd=0 for next 8 samples, then rd_addr=wr_addr-8.
REQ-033 sample_valid toggling 1,0,1,0 in RUN -> wr/rd pulse only after valid cycles; out_valid one cycle after each rd.
REQ-034 Assert rst_n=0 mid-RUN between edges -> all outputs 0 immediately; after release, en=1, offset=2 -> fill restarts at wr_addr 0.

Source files
------------

// File: rtl/sigdelay_ctrl.sv
// ============================================================================
// Module  : sigdelay_ctrl
// Brief   : Write/read pointer controller for a RAM-based signal delay line.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sigdelay_ctrl #(
    parameter int ADDRESS_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     sample_valid,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic                     wr,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic                     rd,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     out_valid,
    output logic                     filling
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] c_ONE = ADDRESS_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wp_q, wp_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] eoff_q, eoff_d;
    logic                     wr_q, wr_d;
    logic                     rd_q, rd_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                     out_valid_q;
    logic                     filling_q;

    logic [ADDRESS_WIDTH-1:0] w_eoff_in;
    logic [ADDRESS_WIDTH-1:0] w_cnt_inc;

    // A zero offset would read the slot being written, so it is promoted to 1.
    assign w_eoff_in = (offset == '0) ? c_ONE : offset;
    assign w_cnt_inc = cnt_q + c_ONE;

    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        cnt_d     = cnt_q;
        eoff_d    = eoff_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;

        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    eoff_d  = w_eoff_in;
                end
                S_FILL, S_RUN: begin
                    if (w_eoff_in != eoff_q) begin
                        // Offset changed: keep writing, but re-prime before reading.
                        state_d = S_FILL;
                        eoff_d  = w_eoff_in;
                        cnt_d   = '0;
                        if (sample_valid) begin
                            wr_d      = 1'b1;
                            wr_addr_d = wp_q;
                            wp_d      = wp_q + c_ONE;
                        end
                    end else if (sample_valid) begin
                        wr_d      = 1'b1;
                        wr_addr_d = wp_q;
                        wp_d      = wp_q + c_ONE;
                        if (state_q == S_FILL) begin
                            cnt_d = w_cnt_inc;
                            if (w_cnt_inc == eoff_q) begin
                                state_d = S_RUN;
                            end
                        end else begin
                            rd_d      = 1'b1;
                            rd_addr_d = wp_q - eoff_q;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wp_q        <= '0;
            cnt_q       <= '0;
            eoff_q      <= c_ONE;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            filling_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            eoff_q      <= eoff_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= rd_q;
            filling_q   <= (state_d == S_FILL);
        end
    end

    assign wr        = wr_q;
    assign rd        = rd_q;
    assign wr_addr   = wr_addr_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign filling   = filling_q;

endmodule

`default_nettype wire
